// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the octal round-robin arbiter.
package arb_pkg;
    localparam int N_REQ      = 8;
    localparam int IDX_W      = 3;
    localparam int HOLD_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;
endpackage

// File: rtl/decoder_octo.sv
// Plain 3-to-8 one-hot decoder.
module decoder_octo (
    input  logic [2:0] sel,
    output logic [7:0] y
);
    always_comb begin
        y = 8'b1 << sel;
    end
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping 7->0.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;

    // Rotate so that bit 0 of rot is requester ptr, then take the lowest set bit.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_REQ-1:0];
        found = |rot;
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = i[IDX_W-1:0];
        end
        idx = ptr + off;
    end
endmodule

// File: rtl/rr_arbiter_octo.sv
// Round-robin arbiter for 8 requesters with registered grant and back-to-back handoff.
// Optional forced revocation of long-held grants is built with `define ARB_TIMEOUT_EN.
module rr_arbiter_octo
    import arb_pkg::*;
#(
    parameter int HOLD_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);
    // Handshake: a requester holds req[i] high until it sees grant[i]; while granted it
    // keeps the resource until it pulses done or drops req[i]; done is ignored unless
    // grant_valid=1, and the next owner is granted on the same edge as the release.
    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [IDX_W-1:0] pick_ptr, pick_idx;
    logic             pick_found;
    logic             release_now;
    logic             revoke;
    logic             timeout_nxt;
    logic [N_REQ-1:0] dec_y;

    // While busy, the search starts just past the owner so it ranks lowest.
    assign pick_ptr = (state == BUSY) ? idx_q + 3'd1 : ptr;

    rr_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign release_now = done || !req[idx_q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [HOLD_CNT_W-1:0] CNT_LAST = HOLD_CNT_W'(HOLD_LIMIT - 1);

    logic [HOLD_CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [N_REQ-1:0]      others;

    always_comb begin
        others = req & ~(N_REQ'(1) << idx_q);
        revoke = (state == BUSY) && !release_now && (hold_cnt == CNT_LAST) && (|others);
    end

    // Cleared on every new grant, otherwise counts busy cycles and saturates at the limit.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (state == IDLE || release_now || revoke) begin
            hold_cnt_nxt = '0;
        end else if (hold_cnt != CNT_LAST) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_cnt <= '0;
        else     hold_cnt <= hold_cnt_nxt;
    end
`else
    logic [HOLD_CNT_W-1:0] unused_hold_limit;
    assign unused_hold_limit = HOLD_CNT_W'(HOLD_LIMIT);
    assign revoke            = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = idx_q;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    idx_nxt   = pick_idx;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (release_now || revoke) begin
                    ptr_nxt     = idx_q + 3'd1;
                    timeout_nxt = revoke;
                    if (pick_found) idx_nxt = pick_idx;
                    else            state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            idx_q   <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            idx_q   <= idx_nxt;
            timeout <= timeout_nxt;
        end
    end

    decoder_octo u_dec (
        .sel (idx_q),
        .y   (dec_y)
    );

    assign grant_valid = (state == BUSY);
    assign grant_idx   = idx_q;
    assign grant       = grant_valid ? dec_y : '0;
endmodule

// File: tb/tb_rr_arbiter_octo.sv
// Self-checking bench for rr_arbiter_octo: directed table, hand sequences, random vs model.
module tb_rr_arbiter_octo;
    localparam int HL = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_checks = 0;
    int n_err    = 0;

    // expected record: {valid, idx, grant, timeout}
    logic [12:0] exp_q[$];

    // reference model state
    bit m_busy;
    int m_idx, m_ptr, m_held;
    bit m_to;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       exp_valid;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter_octo #(.HOLD_LIMIT(HL)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
    endtask

    // One clock of the arbitration rules, applied to the inputs present at the edge.
    task automatic model_step(input logic [7:0] r, input logic d);
        int  w;
        bit  rel, rev, others;
        m_to = 0;
        if (!m_busy) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_idx = w; m_held = 0;
            end
        end else begin
            rel    = d || !r[m_idx];
            others = (r & ~(8'h01 << m_idx)) != 8'h00;
            rev    = TO_EN && !rel && (m_held >= HL - 1) && others;
            if (rel || rev) begin
                m_ptr = (m_idx + 1) % 8;
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_idx = w; m_held = 0;
                end else begin
                    m_busy = 0;
                end
                m_to = rev;
            end else if (m_held < HL - 1) begin
                m_held++;
            end
        end
    endtask

    function automatic logic [12:0] model_out();
        logic [7:0] g;
        logic [2:0] ix;
        ix = 3'(m_idx);
        g  = m_busy ? (8'h01 << m_idx) : 8'h00;
        return {m_busy, ix, g, m_to};
    endfunction

    // driver: apply inputs, clock, sample 1 time unit after the edge
    task automatic step(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    // scoreboard: push model expectation, pop and compare against DUT
    task automatic score(input string tag);
        logic [12:0] e;
        exp_q.push_back(model_out());
        e = exp_q.pop_front();
        check({tag, ".valid"},   grant_valid, e[12]);
        check({tag, ".idx"},     grant_idx,   e[11:9]);
        check({tag, ".grant"},   grant,       e[8:1]);
        check({tag, ".timeout"}, timeout,     e[0]);
    endtask

    task automatic check_idx(input string tag, input logic v, input logic [2:0] ix, input logic to);
        check({tag, ".valid"},   grant_valid, v);
        check({tag, ".idx"},     grant_idx,   ix);
        check({tag, ".grant"},   grant,       v ? (8'h01 << ix) : 8'h00);
        check({tag, ".timeout"}, timeout,     to);
    endtask

    initial begin
        logic [7:0] r;
        logic       d;
        vec_t       v;

        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{8'h94, 1'b0, 1'b1, 3'd2});
        vecs.push_back('{8'h94, 1'b1, 1'b1, 3'd4});
        vecs.push_back('{8'h94, 1'b1, 1'b1, 3'd7});
        vecs.push_back('{8'h83, 1'b1, 1'b1, 3'd0});
        vecs.push_back('{8'h83, 1'b1, 1'b1, 3'd1});
        vecs.push_back('{8'h83, 1'b1, 1'b1, 3'd7});
        vecs.push_back('{8'h20, 1'b1, 1'b1, 3'd5});
        vecs.push_back('{8'h20, 1'b1, 1'b1, 3'd5});
        vecs.push_back('{8'h20, 1'b0, 1'b1, 3'd5});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd5});
        vecs.push_back('{8'h08, 1'b0, 1'b1, 3'd3});
        vecs.push_back('{8'h48, 1'b0, 1'b1, 3'd3});
        vecs.push_back('{8'h40, 1'b1, 1'b1, 3'd6});
        vecs.push_back('{8'h40, 1'b0, 1'b1, 3'd6});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd6});

        // reset
        model_reset();
        #12;
        check_idx("reset", 1'b0, 3'd0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // directed table
        foreach (vecs[i]) begin
            v = vecs[i];
            step(v.req, v.done);
            check_idx($sformatf("vec%0d", i), v.exp_valid, v.exp_idx, 1'b0);
        end

`ifdef ARB_TIMEOUT_EN
        // ptr is 7 here; owner 1 overstays while 2 waits
        step(8'h02, 1'b0);
        check_idx("to_grant", 1'b1, 3'd1, 1'b0);
        for (int c = 0; c < HL - 1; c++) begin
            step(8'h06, 1'b0);
            check_idx($sformatf("to_hold%0d", c), 1'b1, 3'd1, 1'b0);
        end
        step(8'h06, 1'b0);
        check_idx("to_revoke", 1'b1, 3'd2, 1'b1);
        step(8'h06, 1'b0);
        check_idx("to_pulse_end", 1'b1, 3'd2, 1'b0);
        step(8'h02, 1'b0);
        check_idx("to_back1", 1'b1, 3'd1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            step(8'h02, 1'b0);
            check_idx("to_alone", 1'b1, 3'd1, 1'b0);
        end
        step(8'h00, 1'b0);
        check_idx("to_idle", 1'b0, 3'd1, 1'b0);
`endif

        // randomized traffic against the model
        r = 8'h00;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            d = ($urandom_range(0, 3) == 0);
            step(r, d);
            score("rand");
        end

        // asynchronous reset mid-grant
        step(8'h00, 1'b0);
        step(8'h10, 1'b0);
        score("pre_rst");
        #2 rst = 1'b1;
        #1;
        check_idx("async_rst", 1'b0, 3'd0, 1'b0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step(8'h81, 1'b0);
        check_idx("post_rst_prio", 1'b1, 3'd0, 1'b0);
        step(8'h81, 1'b1);
        check_idx("post_rst_next", 1'b1, 3'd7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_octo.md
Name: rr_arbiter_octo

Overview:
- Round-robin arbiter that shares one 8-way resource between 8 requesters, for example a register-file write port or a bus slot.
- Produces a registered 3-bit grant index and the matching one-hot grant vector. The one-hot vector drives the per-requester enables downstream.
- A grant is held until the owner signals done or drops its request. Handoff to the next requester is back-to-back, with no idle cycle.

Parameters:
- HOLD_LIMIT, 16: maximum cycles one owner may hold the grant while others wait. Used only with ARB_TIMEOUT_EN. Legal range 2..255.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- req  input  8  request vector, bit i = requester i
- done  input  1  owner releases the grant; sampled only while grant_valid=1
- grant  output  8  one-hot grant, equal to 1<<grant_idx when grant_valid=1, else 8'h00
- grant_idx  output  3  index of current owner
- grant_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked; always 0 without ARB_TIMEOUT_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: grant=0, grant_idx=0, grant_valid=0, timeout=0, rotating pointer ptr=0, state=IDLE, hold counter=0.
- Reset mid-grant: the grant is dropped immediately and asynchronously. After reset, requester 0 has top priority.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit searching ptr, ptr+1, ... ptr+7 (mod 8).
  - Register the pick into grant_idx, set grant_valid, go to BUSY.
- Latency: a request sampled at edge k gives grant visible after edge k, i.e. one cycle.
- State BUSY:
  - Release condition: done=1, or req[grant_idx]=0. Both true in the same cycle count as a single release.
  - On release, ptr <= grant_idx+1 (mod 8, wraps 7->0).
  - At the same edge, arbitrate again over req using the new ptr. The released requester gets lowest priority.
  - If the search finds a requester, grant it back-to-back and stay in BUSY. Otherwise clear grant_valid and go to IDLE.
  - The released requester is regranted immediately if its req is still high and it is the only requester.
  - No release: all outputs hold. Changes on other req bits are ignored until release.
- done while grant_valid=0 is ignored.
- grant is derived combinationally from the registered grant_idx and grant_valid, so it is glitch-free with respect to req.
- The pointer search is pure combinational over 8 bits. There is no arithmetic beyond 3-bit wrap-around addition.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- With the macro:
  - An 8-bit hold counter clears on every new grant and increments each BUSY cycle.
  - If the counter reaches HOLD_LIMIT-1 with no release, and another req bit is set, the grant is revoked as if released. timeout pulses high for one cycle, coincident with the new grant.
  - If no other requester is pending, the counter saturates and the owner keeps the grant with no pulse.
  - A normal release in the same cycle as the limit takes precedence, and timeout stays 0.
- Without the macro: no counter is synthesized, timeout is tied 0, and HOLD_LIMIT is unused.

Decomposition:
- Shared package arb_pkg:
  - N_REQ=8, IDX_W=3
  - state encoding IDLE=1'b0, BUSY=1'b1
  - HOLD_CNT_W=8
- Sub-module rr_pick: combinational. Inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0] (first set bit at or after ptr, with wrap).
- One-hot generation reuses the team's existing 3-to-8 decoder decoder_octo. Its output is gated with grant_valid.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> grant_valid=0, grant=8'h00 throughout. Assert rst mid-grant -> grant=8'h00 before the next edge.
- After reset, req=8'b1001_0100 -> next cycle grant_idx=2, grant=8'h04. Pulse done -> next cycle grant_idx=4, then grant_idx=7 on the next done.
- Wrap-around: owner 7 releases with req=8'b1000_0011 -> grant_idx=0, then 1, then 7. Verify ptr wraps 7->0.
- Single requester: req=8'h20 held, done pulsed -> grant_idx stays 5, grant_valid never drops. Then drop req[5] -> grant_valid=0 the next cycle, state IDLE.
- Simultaneous release: done=1 and req[3] falls in the same cycle while req[6]=1 -> exactly one handoff to idx 6, with no double advance.
- ARB_TIMEOUT_EN, HOLD_LIMIT=4: owner 1 holds while req[2]=1 -> after 4 BUSY cycles, timeout=1 for one cycle and grant_idx=2. Repeat with only req[1] set -> no timeout and the grant is held indefinitely.
